// File: rtl/mtc_sl_output_queue.sv
// Output queue between the MTC builder and the sector-logic link: compacts up to
// N_MTC_IN valid candidates per clock into a circular FIFO and emits one word per cycle.
module mtc_sl_output_queue #(
  parameter int MTC2SL_LEN     = 32,
  parameter int MTC_WIDTH      = MTC2SL_LEN,
  parameter int N_MTC_IN       = 3,
  parameter int FIFO_DEPTH     = 8,
  parameter int DROP_CNT_WIDTH = 16,
  localparam int PTR_W         = $clog2(FIFO_DEPTH),
  localparam int OCC_W         = PTR_W + 1
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      srst,
  input  logic [MTC_WIDTH-1:0]      mtc_in [N_MTC_IN],
  output logic [MTC_WIDTH-1:0]      mtc_out,
  output logic                      mtc_out_valid,
  input  logic                      mtc_out_ready,
  output logic [OCC_W-1:0]          occupancy,
  output logic                      full,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  // Handshake: a word transfers on a rising edge where mtc_out_valid && mtc_out_ready;
  // while ready is low the presented word and valid stay unchanged.

  localparam logic [OCC_W-1:0] ONE   = OCC_W'(1);
  localparam logic [OCC_W-1:0] DEPTH = OCC_W'(FIFO_DEPTH);

  logic [MTC_WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [OCC_W-1:0]          occ;
  logic [OCC_W-1:0]          free;
  logic [OCC_W-1:0]          nv;
  logic [OCC_W-1:0]          nw;
  logic [OCC_W-1:0]          nd;
  logic [N_MTC_IN-1:0]       wr_en;
  logic [PTR_W-1:0]          wr_addr [N_MTC_IN];
  logic                      pop;
  logic                      do_reset;
  logic [DROP_CNT_WIDTH:0]   drop_sum;
  logic [DROP_CNT_WIDTH-1:0] drop_next;

  assign do_reset = rst | srst;

  // Each accepted input lands at wr_ptr plus the number of accepted inputs below it,
  // which closes gaps left by invalid inputs. Room is judged before any pop.
  always_comb begin
    nv   = '0;
    nw   = '0;
    free = DEPTH - occ;
    for (int i = 0; i < N_MTC_IN; i++) begin
      wr_en[i]   = 1'b0;
      wr_addr[i] = wr_ptr + nw[PTR_W-1:0];
      if (mtc_in[i][MTC_WIDTH-1]) begin
        nv = nv + ONE;
        if (nw < free) begin
          wr_en[i] = 1'b1;
          nw       = nw + ONE;
        end
      end
    end
    nd = nv - nw;
  end

  assign pop = mtc_out_valid & mtc_out_ready;

  always_comb begin
    drop_sum  = {1'b0, drop_count} + (DROP_CNT_WIDTH + 1)'(nd);
    drop_next = drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (do_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      wr_ptr     <= wr_ptr + nw[PTR_W-1:0];
      rd_ptr     <= rd_ptr + PTR_W'(pop);
      occ        <= occ + nw - OCC_W'(pop);
      drop_count <= drop_next;
      if (nd != '0) overflow <= 1'b1;
    end
  end

  // Storage has no reset; pointers and occupancy alone define what is live.
  always_ff @(posedge clock) begin
    if (!do_reset) begin
      for (int i = 0; i < N_MTC_IN; i++) begin
        if (wr_en[i]) mem[wr_addr[i]] <= mtc_in[i];
      end
    end
  end

  assign occupancy     = occ;
  assign full          = (occ == DEPTH);
  assign mtc_out_valid = (occ != '0);
  assign mtc_out       = mtc_out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_mtc_sl_output_queue.sv
// Bench for mtc_sl_output_queue: directed scenarios plus random traffic checked
// against a queue-based reference model and an output scoreboard.
module tb_mtc_sl_output_queue;

  localparam int W     = 16;
  localparam int N     = 3;
  localparam int DEPTH = 8;
  localparam int DCW   = 4;
  localparam int DMAX  = (1 << DCW) - 1;

  logic                 clk;
  logic                 rst;
  logic                 srst;
  logic [W-1:0]         mtc_in [N];
  logic [W-1:0]         mtc_out;
  logic                 mtc_out_valid;
  logic                 mtc_out_ready;
  logic [3:0]           occupancy;
  logic                 full;
  logic                 overflow;
  logic [DCW-1:0]       drop_count;

  logic [W-1:0] stim [N];
  logic [W-1:0] exp_q [$];
  int           mdrop;
  bit           movf;
  int           checks;
  int           errors;

  mtc_sl_output_queue #(
    .MTC_WIDTH(W), .N_MTC_IN(N), .FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(DCW)
  ) dut (
    .clock(clk), .rst(rst), .srst(srst), .mtc_in(mtc_in),
    .mtc_out(mtc_out), .mtc_out_valid(mtc_out_valid), .mtc_out_ready(mtc_out_ready),
    .occupancy(occupancy), .full(full), .overflow(overflow), .drop_count(drop_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer happens at the coming edge when valid && ready.
  always @(negedge clk) begin
    if (!rst && !srst && mtc_out_valid && mtc_out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_empty: got %0h expected no word at %0t", mtc_out, $time);
      end else begin
        chk("pop_data", mtc_out, exp_q.pop_front());
      end
    end
  end

  function automatic logic [W-1:0] rnd_word(input bit v);
    return {v, (W-1)'($urandom)};
  endfunction

  task automatic check_state();
    chk("occupancy", occupancy, exp_q.size());
    chk("full", full, exp_q.size() == DEPTH);
    chk("valid", mtc_out_valid, exp_q.size() != 0);
    chk("overflow", overflow, movf);
    chk("drop_count", drop_count, mdrop);
    if (exp_q.size() == 0) chk("out_zero", mtc_out, 0);
    else                   chk("head", mtc_out, exp_q[0]);
  endtask

  // Driver: presents stim for one cycle; the model accepts the lowest-index valid
  // words that fit in the room left before this cycle's pop.
  task automatic step(input bit rdy);
    int nv;
    int nw;
    int free;
    mtc_in        = stim;
    mtc_out_ready = rdy;
    free = DEPTH - exp_q.size();
    nv = 0;
    nw = 0;
    for (int i = 0; i < N; i++) begin
      if (stim[i][W-1]) begin
        nv++;
        if (nw < free) begin
          exp_q.push_back(stim[i]);
          nw++;
        end
      end
    end
    mdrop = (mdrop + nv - nw > DMAX) ? DMAX : mdrop + nv - nw;
    if (nv > nw) movf = 1'b1;
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic set_stim(input bit v0, input bit v1, input bit v2);
    stim[0] = rnd_word(v0);
    stim[1] = rnd_word(v1);
    stim[2] = rnd_word(v2);
  endtask

  task automatic soft_reset();
    set_stim(1'b1, 1'b1, 1'b1);
    mtc_in        = stim;
    mtc_out_ready = 1'b0;
    srst          = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    exp_q.delete();
    mdrop = 0;
    movf  = 1'b0;
    check_state();
  endtask

  task automatic drain();
    int budget;
    budget = 4 * DEPTH;
    set_stim(1'b0, 1'b0, 1'b0);
    while (exp_q.size() != 0 && budget > 0) begin
      step(1'b1);
      budget--;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mdrop  = 0;
    movf   = 1'b0;
    rst    = 1'b1;
    srst   = 1'b0;
    mtc_out_ready = 1'b0;
    set_stim(1'b1, 1'b1, 1'b1);
    mtc_in = stim;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_state();

    // Gap compaction and one-cycle latency.
    stim[0] = 16'h8a0a;
    stim[1] = 16'h1234;
    stim[2] = 16'h8c0c;
    step(1'b1);
    set_stim(1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b1);

    // Fill with ready low: nine candidates, eight slots.
    for (int c = 0; c < 3; c++) begin
      set_stim(1'b1, 1'b1, 1'b1);
      step(1'b0);
    end
    // Full and popping: a same-cycle pop makes no room.
    set_stim(1'b1, 1'b0, 1'b1);
    step(1'b1);
    drain();

    // Single-word stream wraps the pointers.
    for (int c = 0; c < 20; c++) begin
      case ($urandom_range(0, 2))
        0:       set_stim(1'b1, 1'b0, 1'b0);
        1:       set_stim(1'b0, 1'b1, 1'b0);
        default: set_stim(1'b0, 1'b0, 1'b1);
      endcase
      step(1'b1);
    end
    drain();

    // Soft reset with five queued entries and overflow history.
    for (int c = 0; c < 4; c++) begin
      set_stim(1'b1, 1'b1, 1'b1);
      step(1'b0);
    end
    drain();
    set_stim(1'b1, 1'b1, 1'b1);
    step(1'b0);
    set_stim(1'b1, 1'b0, 1'b1);
    step(1'b0);
    chk("five_queued", occupancy, 5);
    soft_reset();
    step(1'b1);

    // Saturating drop counter.
    for (int c = 0; c < 10; c++) begin
      set_stim(1'b1, 1'b1, 1'b1);
      step(1'b0);
    end
    chk("drop_saturated", drop_count, DMAX);
    drain();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      set_stim($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      step($urandom_range(0, 3) != 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
